mux_nch_scan: RTL and testbench
===============================

# mux_nch_scan

Parametrised, registered N-channel, W-bit multiplexer with a manual-select mode and an auto-scan mode that steps through channels on a programmable dwell count. It generalises the team's fixed 1-bit 4:1 selector and serves as the channel/digit sequencer ahead of display and datapath logic, e.g. time-multiplexed seven-segment drive. Output data and active channel index are registered together, so downstream logic always sees a coherent pair.

## Interface
- WIDTH, 4: bits per channel.
- CHANNELS, 4: number of input channels, 2..16; need not be a power of two.
- SEL_W, 2: select/index width; must satisfy 2^SEL_W >= CHANNELS.
- DWELL, 4: cycles spent on each channel in scan mode, >= 1.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- data_in  in  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  manual channel select.
- mode  in  1  0 = MANUAL, 1 = SCAN.
- hold  in  1  freezes all state and outputs while high.
- y  out  WIDTH  registered selected data.
- ch  out  SEL_W  registered index of the channel currently driving y.
- sel_err  out  1  registered; high when MANUAL and sel >= CHANNELS.
- adv  out  1  one-cycle pulse, registered, on each scan advance.

## Operation
- States: MANUAL, SCAN. The state register follows mode at each edge: state <= mode ? SCAN : MANUAL.
- MANUAL:
  - If sel < CHANNELS: next ch = sel, sel_err = 0.
  - Else: ch holds its previous value, y <= 0, sel_err = 1.
  - Dwell counter is held at 0 and adv = 0.
- SCAN:
  - Dwell counter cnt, width ceil(log2(DWELL)) (min 1), counts 0..DWELL-1.
  - When cnt == DWELL-1: cnt <= 0, ch <= (ch == CHANNELS-1) ? 0 : ch+1, adv <= 1.
  - Otherwise: cnt <= cnt+1, ch unchanged, adv <= 0.
  - sel is ignored and sel_err = 0.
- MANUAL->SCAN transition: scanning starts from the current ch with cnt = 0. The first advance occurs DWELL cycles after the first SCAN edge.
- SCAN->MANUAL transition: takes effect on the same edge mode is sampled low; ch <= sel (subject to the range rule above).
- Data path: on every non-hold edge, y <= data_in slice at the next ch (zero if out of range), so y tracks live data continuously, not only on channel changes.
- hold = 1:
  - y, ch, cnt, state, sel_err are unchanged; adv <= 0.
  - hold has priority over mode changes, advances and sel changes.
- DWELL = 1: advance on every edge in SCAN, so adv stays high continuously.

## Timing
- Reset (asynchronous, immediate): y = 0, ch = 0, sel_err = 0, adv = 0, cnt = 0, state = MANUAL.
- First active edge after reset deassertion behaves as a normal edge.
- Latency: sel/data_in/mode to y/ch/sel_err is 1 cycle, registered, with no combinational path to outputs.
- adv is high in the same cycle that the new ch/y become visible.
- Scan period: each channel is visible for exactly DWELL cycles; a full rotation takes CHANNELS*DWELL cycles, excluding held cycles.
- Reset asserted mid-scan: all state clears at once; after release the block is in MANUAL on channel 0.

## Test plan
Bench parameters: WIDTH=4, CHANNELS=3, SEL_W=2, DWELL=4; data_in = {ch2=4'hC, ch1=4'hB, ch0=4'hA}.
- Reset: assert reset mid-cycle -> y=0, ch=0, sel_err=0, adv=0 with no clock edge; release, sel=0 -> next edge y=4'hA.
- MANUAL select: sel=2 -> one edge later y=4'hC, ch=2. Change ch2 data to 4'h5 -> next edge y=4'h5.
- Out of range: sel=3 in MANUAL -> y=0, ch keeps previous value, sel_err=1. Return sel=1 -> y=4'hB, sel_err=0.
- Scan wrap: start MANUAL ch=1, set mode=1 -> ch sequence 1,1,1,1,2,2,2,2,0,0,0,0,1; adv pulses on the 2, 0 and 1 entries only; y follows A/B/C accordingly.
- Hold: during SCAN at cnt=2 on ch=2, assert hold for 5 cycles -> y, ch frozen, adv=0. Release -> ch advances to 0 after exactly 2 more edges.
- Reset mid-scan: reset pulse while ch=2 -> immediate y=0, ch=0. After release with mode=1 -> first advance to ch=1 occurs 4 edges after the first post-reset edge.

Source files
------------

// File: rtl/mux_nch_scan.sv
// Registered N-channel mux with manual select and dwell-timed auto-scan; 1-cycle latency.
// No backpressure: hold freezes all state and outputs; y/ch/sel_err/adv update together.
module mux_nch_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          ch,
  output logic                      sel_err,
  output logic                      adv
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]    CNT_MAX = CW'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   CH_NUM  = (SEL_W + 1)'(CHANNELS);

  localparam logic [0:0] MANUAL = 1'b0;
  localparam logic [0:0] SCAN   = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [SEL_W-1:0] ch_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic             err_nxt, adv_nxt, sel_ok;

  assign sel_ok = ({1'b0, sel} < CH_NUM);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ch_nxt    = ch;
    err_nxt   = sel_err;
    adv_nxt   = 1'b0;
    y_nxt     = y;
    if (!hold) begin
      state_nxt = mode ? SCAN : MANUAL;
      err_nxt   = 1'b0;
      if (!mode) begin
        cnt_nxt = '0;
        if (sel_ok) ch_nxt = sel;
        else        err_nxt = 1'b1;
      end else if (state == MANUAL) begin
        // entry edge: scanning begins from the current channel with a fresh dwell
        cnt_nxt = '0;
      end else if (cnt == CNT_MAX) begin
        cnt_nxt = '0;
        ch_nxt  = (ch == LAST_CH) ? '0 : ch + SEL_W'(1);
        adv_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
      y_nxt = '0;
      if (!err_nxt) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (ch_nxt == SEL_W'(k)) y_nxt = data_in[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MANUAL;
      cnt     <= '0;
      ch      <= '0;
      y       <= '0;
      sel_err <= 1'b0;
      adv     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ch      <= ch_nxt;
      y       <= y_nxt;
      sel_err <= err_nxt;
      adv     <= adv_nxt;
    end
  end

endmodule

// File: tb/tb_mux_nch_scan.sv
// Bench for mux_nch_scan: directed scenarios plus random traffic against a cycle-level model.
module tb_mux_nch_scan;

  localparam int WIDTH = 4, CH = 3, SEL_W = 2, DWELL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] chan [3];
  logic [CH*WIDTH-1:0] data_in;
  logic [SEL_W-1:0] sel = '0;
  logic mode = 1'b0, hold = 1'b0;
  logic [WIDTH-1:0] y, y1;
  logic [SEL_W-1:0] ch, ch1;
  logic sel_err, adv, sel_err1, adv1;

  int n_checks = 0, n_fail = 0;

  // model state
  bit scanning = 0;
  int m_vis = 0, m_ch = 0;
  logic [3:0] m_y = '0;
  logic m_err = 1'b0, m_adv = 1'b0;

  assign data_in = {chan[2], chan[1], chan[0]};

  always #5 clk = ~clk;

  mux_nch_scan #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .sel(sel), .mode(mode), .hold(hold),
    .y(y), .ch(ch), .sel_err(sel_err), .adv(adv));

  mux_nch_scan #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SEL_W), .DWELL(1)) dut_d1 (
    .clk(clk), .reset(reset), .data_in(data_in), .sel(sel), .mode(mode), .hold(hold),
    .y(y1), .ch(ch1), .sel_err(sel_err1), .adv(adv1));

  task automatic model_reset();
    scanning = 0; m_vis = 0; m_ch = 0; m_y = '0; m_err = 1'b0; m_adv = 1'b0;
  endtask

  // Advance the model by one edge from the inputs present now, then step past the edge.
  task automatic tick();
    if (hold) begin
      m_adv = 1'b0;
    end else if (!mode) begin
      scanning = 0; m_adv = 1'b0;
      if (int'(sel) < CH) begin m_ch = int'(sel); m_err = 1'b0; m_y = chan[sel]; end
      else begin m_err = 1'b1; m_y = '0; end
    end else begin
      m_err = 1'b0; m_adv = 1'b0;
      if (!scanning) begin
        scanning = 1; m_vis = 0;
      end else begin
        m_vis++;
        if (m_vis == DWELL) begin m_vis = 0; m_ch = (m_ch + 1) % CH; m_adv = 1'b1; end
      end
      m_y = chan[m_ch];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mode = 0; sel = 2'd1; hold = 0; reset = 1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if ({y, ch, sel_err, adv} !== 8'h00) begin n_fail++;
      $display("FAIL reset_hold: y=%h ch=%0d err=%b adv=%b, want all zero", y, ch, sel_err, adv); end
    reset = 0; model_reset();
    tick();
    n_checks++; if (y !== 4'hB) begin n_fail++; $display("FAIL reset_pre_sel1: y=%h want b", y); end
    #3 reset = 1; #1;
    n_checks++; if ({y, ch, sel_err, adv} !== 8'h00) begin n_fail++;
      $display("FAIL reset_async: y=%h ch=%0d err=%b adv=%b, want all zero", y, ch, sel_err, adv); end
    #1 reset = 0; model_reset();
    sel = 2'd0;
    tick();
    n_checks++; if (y !== 4'hA || ch !== 2'd0) begin n_fail++;
      $display("FAIL reset_release: y=%h ch=%0d want a/0", y, ch); end
  endtask

  task automatic test_manual();
    mode = 0; sel = 2'd2; tick();
    n_checks++; if (y !== 4'hC || ch !== 2'd2 || sel_err !== 1'b0) begin n_fail++;
      $display("FAIL manual_sel2: y=%h ch=%0d err=%b want c/2/0", y, ch, sel_err); end
    chan[2] = 4'h5; tick();
    n_checks++; if (y !== 4'h5) begin n_fail++; $display("FAIL manual_live: y=%h want 5", y); end
    chan[2] = 4'hC;
  endtask

  task automatic test_out_of_range();
    mode = 0; sel = 2'd2; tick();
    sel = 2'd3; tick();
    n_checks++; if (y !== 4'h0 || ch !== 2'd2 || sel_err !== 1'b1) begin n_fail++;
      $display("FAIL oor_sel3: y=%h ch=%0d err=%b want 0/2/1", y, ch, sel_err); end
    sel = 2'd1; tick();
    n_checks++; if (y !== 4'hB || ch !== 2'd1 || sel_err !== 1'b0) begin n_fail++;
      $display("FAIL oor_return: y=%h ch=%0d err=%b want b/1/0", y, ch, sel_err); end
  endtask

  task automatic test_scan_wrap();
    int exp_ch [13] = '{1,1,1,1,2,2,2,2,0,0,0,0,1};
    logic [3:0] vals [3];
    vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC;
    mode = 0; sel = 2'd1; tick();
    mode = 1; sel = 2'd3;
    for (int i = 0; i < 13; i++) begin
      tick();
      n_checks++;
      if (int'(ch) != exp_ch[i] || adv !== ((i % 4 == 0) && i != 0) || y !== vals[exp_ch[i]]
          || sel_err !== 1'b0) begin
        n_fail++;
        $display("FAIL scan_wrap[%0d]: ch=%0d adv=%b y=%h err=%b want ch=%0d adv=%b y=%h err=0",
                 i, ch, adv, y, sel_err, exp_ch[i], (i % 4 == 0) && i != 0, vals[exp_ch[i]]);
      end
    end
  endtask

  task automatic test_hold();
    mode = 0; sel = 2'd2; tick();
    mode = 1; tick(); tick(); tick();
    hold = 1;
    for (int i = 0; i < 5; i++) begin
      mode = i[0]; sel = 2'(i);
      tick();
      n_checks++;
      if (ch !== 2'd2 || y !== 4'hC || adv !== 1'b0) begin n_fail++;
        $display("FAIL hold[%0d]: ch=%0d y=%h adv=%b want 2/c/0", i, ch, y, adv); end
    end
    hold = 0; mode = 1;
    tick();
    n_checks++; if (ch !== 2'd2 || adv !== 1'b0) begin n_fail++;
      $display("FAIL hold_rel1: ch=%0d adv=%b want 2/0", ch, adv); end
    tick();
    n_checks++; if (ch !== 2'd0 || adv !== 1'b1 || y !== 4'hA) begin n_fail++;
      $display("FAIL hold_rel2: ch=%0d adv=%b y=%h want 0/1/a", ch, adv, y); end
  endtask

  task automatic test_reset_midscan();
    int first_adv = 0;
    mode = 1;
    for (int i = 0; i < 20 && ch !== 2'd2; i++) tick();
    n_checks++; if (ch !== 2'd2) begin n_fail++; $display("FAIL midscan_reach: ch=%0d want 2", ch); end
    #2 reset = 1; #1;
    n_checks++; if (y !== 4'h0 || ch !== 2'd0 || adv !== 1'b0) begin n_fail++;
      $display("FAIL midscan_async: y=%h ch=%0d adv=%b want 0/0/0", y, ch, adv); end
    #2 reset = 0; model_reset();
    for (int e = 1; e <= 10 && first_adv == 0; e++) begin
      tick();
      if (adv === 1'b1) first_adv = e;
    end
    n_checks++; if (first_adv != 5 || ch !== 2'd1) begin n_fail++;
      $display("FAIL midscan_first_adv: edge=%0d ch=%0d want edge 5 ch 1", first_adv, ch); end
  endtask

  task automatic test_dwell1();
    mode = 0; sel = 2'd0; tick();
    mode = 1; tick();
    n_checks++; if (ch1 !== 2'd0 || adv1 !== 1'b0) begin n_fail++;
      $display("FAIL dwell1_entry: ch=%0d adv=%b want 0/0", ch1, adv1); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (int'(ch1) != k % CH || adv1 !== 1'b1 || y1 !== chan[k % CH]) begin n_fail++;
        $display("FAIL dwell1[%0d]: ch=%0d adv=%b y=%h want %0d/1/%h", k, ch1, adv1, y1, k % CH,
                 chan[k % CH]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < CH; k++) chan[k] = 4'($urandom);
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      hold = ($urandom_range(0, 9) == 0);
      tick();
      n_checks++;
      if (y !== m_y || int'(ch) != m_ch || sel_err !== m_err || adv !== m_adv) begin n_fail++;
        $display("FAIL random[%0d]: y=%h ch=%0d err=%b adv=%b want y=%h ch=%0d err=%b adv=%b",
                 i, y, ch, sel_err, adv, m_y, m_ch, m_err, m_adv); end
    end
    hold = 0;
  endtask

  initial begin
    chan[0] = 4'hA; chan[1] = 4'hB; chan[2] = 4'hC;
    test_reset();
    test_manual();
    test_out_of_range();
    test_scan_wrap();
    test_hold();
    test_reset_midscan();
    test_dwell1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
